polyvecl_pack_z: RTL

- Packs the signature vector z (L polynomials, 256 signed 32-bit coefficients each) into the Dilithium signature byte format.
- Each coefficient is encoded as GAMMA1 - coeff in 20 bits, little-endian contiguous.
- This is the consumer-side counterpart of the gamma1 vector sampler: it serializes a vector in that sampler's wide-bus layout.
- Sits in the signing datapath after z = y + c*s1 and feeds the signature assembler.

---
 rtl/polyvecl_pack_z.sv | 132 +++++++++++++
 1 files changed

// File: rtl/polyvecl_pack_z.sv
// Packs signature vector z (L x N signed 32-bit coefficients) into 20-bit GAMMA1-coeff fields, LANES per cycle.
// Optional sticky out-of-range flag enabled by defining POLYVECL_PACK_Z_NORM_CHECK_EN.
module polyvecl_pack_z #(
  parameter int unsigned L          = 5,
  parameter int unsigned N          = 256,
  parameter int unsigned GAMMA1     = 524288,
  parameter int unsigned COEFF_BITS = 20,
  parameter int unsigned LANES      = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [L*N*32-1:0]          z_in,
  output logic [L*N*COEFF_BITS-1:0]  packed_out,
  output logic                       done
`ifdef POLYVECL_PACK_Z_NORM_CHECK_EN
  ,
  output logic                       range_err
`endif
);

  localparam int unsigned TOTAL = L * N;
  localparam int unsigned CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TOTAL - LANES);
  localparam logic [CW-1:0] STEP     = CW'(LANES);
  localparam logic signed [32:0] G33 = 33'(GAMMA1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PACK,
    S_DONE
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [CW-1:0]               r_cnt;
  logic [TOTAL*32-1:0]         r_z;
  logic [TOTAL*COEFF_BITS-1:0] r_packed;
  logic                        r_done;
  logic                        w_last;
  logic [31:0]                 w_base;
  logic signed [32:0]          w_ext   [LANES];
  logic signed [32:0]          w_diff  [LANES];
  logic [COEFF_BITS-1:0]       w_field [LANES];
`ifdef POLYVECL_PACK_Z_NORM_CHECK_EN
  logic                        r_err;
  logic                        w_bad;
`endif

  assign w_last = (r_cnt == LAST_CNT);
  assign w_base = 32'(r_cnt);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  w_next = S_PACK;
      S_PACK:  if (w_last) w_next = S_DONE;
      S_DONE:  if (!start) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Flat index cnt+m addresses both layouts directly, since N*32 per polynomial is contiguous.
  always_comb begin
    for (int unsigned m = 0; m < LANES; m++) begin
      w_ext[m]   = 33'($signed(r_z[(w_base + m)*32 +: 32]));
      w_diff[m]  = G33 - w_ext[m];
      w_field[m] = w_diff[m][COEFF_BITS-1:0];
    end
  end

`ifdef POLYVECL_PACK_Z_NORM_CHECK_EN
  always_comb begin
    w_bad = 1'b0;
    for (int unsigned m = 0; m < LANES; m++) begin
      if ((w_ext[m] <= -G33) || (w_ext[m] > G33)) w_bad = 1'b1;
    end
  end
`endif

  // Counter holds on the final PACK cycle so lane reads never run past the vector.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_z      <= '0;
      r_packed <= '0;
      r_done   <= 1'b0;
`ifdef POLYVECL_PACK_Z_NORM_CHECK_EN
      r_err    <= 1'b0;
`endif
    end else begin
      r_done <= (w_next == S_DONE);
      case (r_state)
        S_LOAD: begin
          r_z      <= z_in;
          r_packed <= '0;
          r_cnt    <= '0;
`ifdef POLYVECL_PACK_Z_NORM_CHECK_EN
          r_err    <= 1'b0;
`endif
        end
        S_PACK: begin
          for (int unsigned m = 0; m < LANES; m++) begin
            r_packed[(w_base + m)*COEFF_BITS +: COEFF_BITS] <= w_field[m];
          end
          if (!w_last) r_cnt <= r_cnt + STEP;
`ifdef POLYVECL_PACK_Z_NORM_CHECK_EN
          r_err <= r_err | w_bad;
`endif
        end
        default: ;
      endcase
    end
  end

  assign packed_out = r_packed;
  assign done       = r_done;
`ifdef POLYVECL_PACK_Z_NORM_CHECK_EN
  assign range_err  = r_err;
`endif

endmodule
